// File: rtl/dog_pkg.sv
// dog_pkg: shared state encoding and timing constants for the DoG octave scheduler
package dog_pkg;
  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, GAP, DONE} dog_sched_state;
  localparam int DEF_START_TIMEOUT = 8;
  localparam int GAP_CYCLES = 2;
endpackage

// File: rtl/dog_scheduler_if.sv
// dog_scheduler_if: octave/engine handshake and BRAM select bundle around the scheduler
interface dog_scheduler_if #(
  parameter int NUM_GAUSS = 4
);
  localparam int SEL_W = $clog2(NUM_GAUSS);
  logic octave_ready;
  logic dog_busy;
  logic dog_start;
  logic [SEL_W-1:0] sharp_sel;
  logic [SEL_W-1:0] fuzz_sel;
  logic [SEL_W-1:0] dog_sel;
  logic octave_busy;
  logic octave_done;
  logic timeout_err;
  logic overrun;
  modport master (
    input octave_ready, dog_busy,
    output dog_start, sharp_sel, fuzz_sel, dog_sel, octave_busy, octave_done, timeout_err, overrun
  );
  modport slave (
    output octave_ready, dog_busy,
    input dog_start, sharp_sel, fuzz_sel, dog_sel, octave_busy, octave_done, timeout_err, overrun
  );
endinterface

// File: rtl/dog_scheduler_rise_detect.sv
// rise_detect: registered one-cycle pulse on each low-to-high transition of d
module rise_detect (
  input  logic clk,
  input  logic rst_in,
  input  logic d,
  output logic rise
);
  logic prev;
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      prev <= d;
      rise <= d & ~prev;
    end
  end
endmodule

// File: rtl/dog_scheduler.sv
// dog_scheduler: steps the DoG engine through every adjacent Gaussian pair of an octave
module dog_scheduler
  import dog_pkg::*;
#(
  parameter int NUM_GAUSS = 4,
  parameter int START_TIMEOUT = DEF_START_TIMEOUT
) (
  input logic clk,
  input logic rst_in,
  dog_scheduler_if.master bus
);
  localparam int SEL_W = $clog2(NUM_GAUSS);
  localparam int CW = $clog2(START_TIMEOUT + GAP_CYCLES) + 1;
  dog_sched_state state, state_n;
  logic [SEL_W-1:0] pair, pair_n, fuzz, dsel;
  logic [CW-1:0] cnt, cnt_n;
  logic start, start_n, busy, busy_n, done, done_n, terr, terr_n, ovr, ovr_n, rise;
  rise_detect u_rise (.clk(clk), .rst_in(rst_in), .d(bus.octave_ready), .rise(rise));
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
      pair  <= '0;
      fuzz  <= '0;
      dsel  <= '0;
      cnt   <= '0;
      start <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      terr  <= 1'b0;
      ovr   <= 1'b0;
    end else begin
      state <= state_n;
      pair  <= pair_n;
      fuzz  <= pair_n + 1'b1;
      dsel  <= pair_n;
      cnt   <= cnt_n;
      start <= start_n;
      busy  <= busy_n;
      done  <= done_n;
      terr  <= terr_n;
      ovr   <= ovr_n;
    end
  end
  // dog_start is only raised on the second LAUNCH cycle so the selects settle first
  always_comb begin
    state_n = state;
    pair_n  = pair;
    cnt_n   = cnt;
    start_n = start;
    busy_n  = busy;
    done_n  = 1'b0;
    terr_n  = terr;
    ovr_n   = ovr | (rise & busy);
    case (state)
      IDLE: if (rise) begin
        state_n = LAUNCH;
        pair_n  = '0;
        busy_n  = 1'b1;
      end
      LAUNCH: if (!start) begin
        start_n = 1'b1;
        cnt_n   = '0;
      end else if (bus.dog_busy) begin
        start_n = 1'b0;
        state_n = RUN;
      end else if (cnt == CW'(START_TIMEOUT - 1)) begin
        start_n = 1'b0;
        busy_n  = 1'b0;
        terr_n  = 1'b1;
        state_n = IDLE;
      end else cnt_n = cnt + 1'b1;
      RUN: if (!bus.dog_busy) begin
        state_n = GAP;
        cnt_n   = '0;
      end
      GAP: if (cnt == CW'(GAP_CYCLES - 1)) begin
        if (pair == SEL_W'(NUM_GAUSS - 2)) begin
          state_n = DONE;
          done_n  = 1'b1;
          busy_n  = 1'b0;
        end else begin
          state_n = LAUNCH;
          pair_n  = pair + 1'b1;
        end
      end else cnt_n = cnt + 1'b1;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign bus.dog_start   = start;
  assign bus.sharp_sel   = pair;
  assign bus.fuzz_sel    = fuzz;
  assign bus.dog_sel     = dsel;
  assign bus.octave_busy = busy;
  assign bus.octave_done = done;
  assign bus.timeout_err = terr;
  assign bus.overrun     = ovr;
endmodule
